// File: rtl/gmii_rx_pkg.sv
// rtl/gmii_rx_pkg.sv - shared constants and FSM encoding for the GMII receive path
package gmii_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int          DLY_DEPTH     = 5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_DATA     = 2'd2;
    localparam logic [1:0] ST_DROP     = 2'd3;

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational reflected CRC32 update for one data byte, LSB first
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// rtl/gmii_rx_frame.sv - GMII rx framer: preamble/SFD strip, FCS strip, CRC and length check; DA filter with GMII_RX_MAC_FILTER_EN
module gmii_rx_frame
    import gmii_rx_pkg::*;
#(
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518,
    parameter logic [47:0] MAC_ADDR = 48'h00_22_CF_00_00_01
) (
    input  logic        rx_clk,
    input  logic        sys_rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_good,
    output logic [10:0] frame_len,
    output logic        stat_crc_err,
    output logic        stat_drop
);

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [10:0] DLY_L   = 11'(DLY_DEPTH);
    localparam logic [10:0] CNT_SAT = 11'h7FF;
    localparam logic [3:0]  PRE_MAX = 4'd7;

    logic [1:0]                  state_q, state_d;
    logic [3:0]                  pre_cnt_q, pre_cnt_d;
    logic [10:0]                 byte_cnt_q, byte_cnt_d;
    logic [31:0]                 crc_q, crc_d, crc_next;
    logic [DLY_DEPTH-1:0][7:0]   dly_q, dly_d;
    logic                        sof_pend_q, sof_pend_d;
    logic                        valid_q, valid_d;
    logic [7:0]                  data_q, data_d;
    logic                        sof_q, sof_d;
    logic                        eof_q, eof_d;
    logic                        good_q, good_d;
    logic [10:0]                 len_q, len_d;
    logic                        crc_err_q, crc_err_d;
    logic                        drop_q, drop_d;

    crc32_d8 u_crc (
        .crc_i  (crc_q),
        .data_i (rxd),
        .crc_o  (crc_next)
    );

`ifdef GMII_RX_MAC_FILTER_EN
    // The sixth DA byte is still on rxd; the first five sit in the delay line.
    logic [47:0] da;
    logic        da_ok;
    assign da    = {dly_q[0], dly_q[1], dly_q[2], dly_q[3], dly_q[4], rxd};
    assign da_ok = (da == MAC_ADDR) || (da == BCAST_MAC);
`endif

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        dly_d      = dly_q;
        sof_pend_d = sof_pend_q;
        valid_d    = 1'b0;
        data_d     = 8'h00;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        good_d     = 1'b0;
        len_d      = 11'd0;
        crc_err_d  = 1'b0;
        drop_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_dv) begin
                    if (rxd == PREAMBLE_BYTE) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d = ST_DROP;
                        drop_d  = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end else if (rxd == PREAMBLE_BYTE) begin
                    if (pre_cnt_q >= PRE_MAX) begin
                        state_d = ST_DROP;
                        drop_d  = 1'b1;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end
                end else if (rxd == SFD_BYTE) begin
                    state_d    = ST_DATA;
                    crc_d      = CRC_INIT;
                    byte_cnt_d = 11'd0;
                    sof_pend_d = 1'b1;
                end else begin
                    state_d = ST_DROP;
                    drop_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_dv) begin
                    dly_d      = {rxd, dly_q[DLY_DEPTH-1:1]};
                    crc_d      = crc_next;
                    byte_cnt_d = (byte_cnt_q == CNT_SAT) ? CNT_SAT : byte_cnt_q + 11'd1;
                    if (byte_cnt_q >= DLY_L) begin
                        valid_d    = 1'b1;
                        data_d     = dly_q[0];
                        sof_d      = sof_pend_q;
                        sof_pend_d = 1'b0;
                    end
`ifdef GMII_RX_MAC_FILTER_EN
                    if (byte_cnt_q == DLY_L && !da_ok) begin
                        valid_d = 1'b0;
                        data_d  = 8'h00;
                        sof_d   = 1'b0;
                        drop_d  = 1'b1;
                        state_d = ST_DROP;
                    end
`endif
                end else begin
                    // The four bytes left behind in the delay line are the FCS.
                    state_d = ST_IDLE;
                    if (byte_cnt_q >= DLY_L) begin
                        valid_d    = 1'b1;
                        data_d     = dly_q[0];
                        sof_d      = sof_pend_q;
                        sof_pend_d = 1'b0;
                        eof_d      = 1'b1;
                        len_d      = byte_cnt_q;
                        good_d     = (crc_q == CRC_RESIDUE) && (byte_cnt_q >= MIN_L)
                                     && (byte_cnt_q <= MAX_L);
                        crc_err_d  = (crc_q != CRC_RESIDUE);
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            default: begin
                if (!rx_dv) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            pre_cnt_q  <= 4'd0;
            byte_cnt_q <= 11'd0;
            crc_q      <= 32'd0;
            dly_q      <= '0;
            sof_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            good_q     <= 1'b0;
            len_q      <= 11'd0;
            crc_err_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            dly_q      <= dly_d;
            sof_pend_q <= sof_pend_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            good_q     <= good_d;
            len_q      <= len_d;
            crc_err_q  <= crc_err_d;
            drop_q     <= drop_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_data     = data_q;
    assign out_sof      = sof_q;
    assign out_eof      = eof_q;
    assign out_good     = good_q;
    assign frame_len    = len_q;
    assign stat_crc_err = crc_err_q;
    assign stat_drop    = drop_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb/tb_gmii_rx_frame.sv - randomized self-checking bench for gmii_rx_frame
module tb_gmii_rx_frame;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        good;
        logic [10:0] len;
        logic        crc_err;
        int          cyc;
    } rec_t;

    localparam logic [47:0] MAC = 48'h00_22_CF_00_00_01;

    logic        rx_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        out_good;
    logic [10:0] frame_len;
    logic        stat_crc_err;
    logic        stat_drop;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   first_cyc = 0;
    int   drop_cnt = 0;
    int   crc_cnt = 0;
    rec_t cap[$];

    gmii_rx_frame dut (
        .rx_clk       (rx_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_dv        (rx_dv),
        .rxd          (rxd),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .out_good     (out_good),
        .frame_len    (frame_len),
        .stat_crc_err (stat_crc_err),
        .stat_drop    (stat_drop)
    );

    initial forever #4 rx_clk = ~rx_clk;
    initial forever begin @(posedge rx_clk); cyc++; end

    initial forever begin
        @(negedge rx_clk);
        if (out_valid) cap.push_back('{out_data, out_sof, out_eof, out_good, frame_len, stat_crc_err, cyc});
        if (stat_drop) drop_cnt++;
        if (stat_crc_err) crc_cnt++;
    end

    // Ethernet FCS: CRC32 of the bytes, complemented, sent low byte first.
    function automatic bq_t add_fcs(input bq_t p);
        logic [31:0] c = 32'hFFFF_FFFF;
        bq_t r = p;
        for (int i = 0; i < p.size(); i++) begin
            c ^= {24'd0, p[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) r.push_back(c[8*i +: 8]);
        return r;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(8'($urandom_range(0, 255)));
        return r;
    endfunction

    // Expected result of a framed byte stream: payload, length, status.
    function automatic void model(input bq_t data, output bq_t pay, output logic [10:0] len,
                                  output logic good, output logic crc_bad);
        int n = data.size();
        bq_t body;
        bq_t ref_frame;
        pay = {};
        for (int i = 0; i < n - 4; i++) body.push_back(data[i]);
        ref_frame = add_fcs(body);
        crc_bad = (ref_frame != data);
        for (int i = 0; i < n - 4; i++) pay.push_back(data[i]);
        len = (n > 2047) ? 11'd2047 : 11'(n);
        good = !crc_bad && n >= 64 && n <= 1518;
    endfunction

    task automatic drive(input logic dv, input logic [7:0] b);
        @(posedge rx_clk);
        #1;
        rx_dv = dv;
        rxd = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic send_frame(input bq_t data, input int npre);
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < data.size(); i++) begin
            drive(1'b1, data[i]);
            if (i == 0) first_cyc = cyc;
        end
        drive(1'b0, 8'h00);
    endtask

    task automatic clear_cap();
        cap = {};
        drop_cnt = 0;
        crc_cnt = 0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        idle(3);
        @(negedge rx_clk);
        n_checks++;
        if ({out_valid, out_data, out_sof, out_eof, out_good, frame_len, stat_crc_err, stat_drop} !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b data=%02h sof=%0b eof=%0b good=%0b len=%0d crc=%0b drop=%0b, want all 0",
                     out_valid, out_data, out_sof, out_eof, out_good, frame_len, stat_crc_err, stat_drop);
        end
        @(posedge rx_clk); #1; sys_rst_n = 1'b1;
        idle(3);
        n_checks++;
        if (cap.size() != 0 || drop_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got bytes=%0d drops=%0d, want 0 0", cap.size(), drop_cnt);
        end
    endtask

    task automatic test_good_frame(input bq_t data, input string tag);
        bq_t pay;
        logic [10:0] len;
        logic good, bad;
        int mis = 0, sof_n = 0, eof_n = 0;
        model(data, pay, len, good, bad);
        clear_cap();
        send_frame(data, 7);
        idle(8);
        n_checks++;
        if (cap.size() != pay.size()) begin
            n_fail++;
            $display("FAIL %s_count: got %0d bytes, want %0d", tag, cap.size(), pay.size());
        end
        for (int i = 0; i < cap.size() && i < pay.size(); i++) begin
            if (cap[i].d !== pay[i]) mis++;
            if (cap[i].sof) sof_n++;
            if (cap[i].eof) eof_n++;
        end
        n_checks++;
        if (mis != 0) begin
            n_fail++;
            $display("FAIL %s_data: got %0d mismatched bytes, want 0", tag, mis);
        end
        if (cap.size() > 0) begin
            n_checks++;
            if (!(cap[0].sof && cap[cap.size()-1].eof && sof_n == 1 && eof_n == 1)) begin
                n_fail++;
                $display("FAIL %s_markers: got sof0=%0b eoflast=%0b nsof=%0d neof=%0d, want 1 1 1 1",
                         tag, cap[0].sof, cap[cap.size()-1].eof, sof_n, eof_n);
            end
            n_checks++;
            if (cap[cap.size()-1].len !== len || cap[cap.size()-1].good !== good
                || cap[cap.size()-1].crc_err !== bad) begin
                n_fail++;
                $display("FAIL %s_status: got len=%0d good=%0b crc_err=%0b, want %0d %0b %0b", tag,
                         cap[cap.size()-1].len, cap[cap.size()-1].good, cap[cap.size()-1].crc_err, len, good, bad);
            end
            n_checks++;
            if (cap[0].cyc != first_cyc + 6) begin
                n_fail++;
                $display("FAIL %s_latency: got sof at cycle %0d, want %0d", tag, cap[0].cyc, first_cyc + 6);
            end
        end
        n_checks++;
        if (crc_cnt != (bad ? 1 : 0) || drop_cnt != 0) begin
            n_fail++;
            $display("FAIL %s_stats: got crc_err=%0d drop=%0d, want %0d 0", tag, crc_cnt, drop_cnt, bad ? 1 : 0);
        end
    endtask

    task automatic test_bad_crc();
        bq_t data = add_fcs(rand_bytes(60));
        data[10] = ~data[10];
        test_good_frame(data, "bad_crc");
    endtask

    task automatic test_drop_cases();
        bq_t data;
        for (int k = 0; k < 2; k++) begin
            clear_cap();
            if (k == 0) begin
                drive(1'b1, 8'hAB);
                for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom_range(0, 255)));
                idle(2);
            end else begin
                for (int i = 0; i < 9; i++) drive(1'b1, 8'h55);
                drive(1'b1, 8'hD5);
                for (int i = 0; i < 20; i++) drive(1'b1, 8'($urandom_range(0, 255)));
                idle(2);
            end
            n_checks++;
            if (cap.size() != 0 || drop_cnt != 1) begin
                n_fail++;
                $display("FAIL drop_case%0d: got bytes=%0d drops=%0d, want 0 1", k, cap.size(), drop_cnt);
            end
            data = add_fcs(rand_bytes(60));
            test_good_frame(data, "after_drop");
        end
    endtask

    task automatic test_back_to_back();
        bq_t a = add_fcs(rand_bytes(60));
        bq_t b = add_fcs(rand_bytes(60));
        int sof_n = 0, eof_n = 0, good_n = 0, mis = 0;
        clear_cap();
        send_frame(a, 7);
        send_frame(b, 7);
        idle(8);
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i].sof) sof_n++;
            if (cap[i].eof) eof_n++;
            if (cap[i].eof && cap[i].good) good_n++;
            if (i < 60 && cap[i].d !== a[i]) mis++;
            if (i >= 60 && i < 120 && cap[i].d !== b[i-60]) mis++;
        end
        n_checks++;
        if (cap.size() != 120 || sof_n != 2 || eof_n != 2 || good_n != 2 || mis != 0) begin
            n_fail++;
            $display("FAIL back_to_back: got bytes=%0d sof=%0d eof=%0d good=%0d mis=%0d, want 120 2 2 2 0",
                     cap.size(), sof_n, eof_n, good_n, mis);
        end
    endtask

    task automatic test_lengths();
        int lens[8] = '{5, 4, 63, 64, 1518, 1519, 2100, 0};
        lens[7] = $urandom_range(65, 300);
        for (int j = 0; j < 8; j++) begin
            if (lens[j] >= 5) begin
                test_good_frame(add_fcs(rand_bytes(lens[j] - 4)), $sformatf("len%0d", lens[j]));
            end else begin
                clear_cap();
                send_frame(rand_bytes(lens[j]), 7);
                idle(8);
                n_checks++;
                if (cap.size() != 0 || drop_cnt != 1 || crc_cnt != 0) begin
                    n_fail++;
                    $display("FAIL runt_len%0d: got bytes=%0d drops=%0d crc=%0d, want 0 1 0",
                             lens[j], cap.size(), drop_cnt, crc_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bq_t data = add_fcs(rand_bytes(60));
        int eof_n = 0, mis = 0;
        for (int i = 0; i < data.size(); i++) if (data[i] == 8'h55 || data[i] == 8'hD5) data[i] = 8'h00;
        clear_cap();
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < data.size(); i++) begin
            drive(1'b1, data[i]);
            if (i == 20) sys_rst_n = 1'b0;
            if (i == 22) sys_rst_n = 1'b1;
            if (i == 21) begin
                @(negedge rx_clk);
                n_checks++;
                if ({out_valid, out_sof, out_eof, out_good, frame_len, stat_crc_err, stat_drop} !== 17'd0) begin
                    n_fail++;
                    $display("FAIL midreset_outputs: got valid=%0b eof=%0b drop=%0b, want 0 0 0",
                             out_valid, out_eof, stat_drop);
                end
            end
        end
        drive(1'b0, 8'h00);
        idle(8);
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i].eof) eof_n++;
            if (i < 60 && cap[i].d !== data[i]) mis++;
        end
        n_checks++;
        if (eof_n != 0 || drop_cnt != 1 || crc_cnt != 0 || cap.size() != 15 || mis != 0) begin
            n_fail++;
            $display("FAIL midreset_result: got eof=%0d drops=%0d crc=%0d bytes=%0d mis=%0d, want 0 1 0 15 0",
                     eof_n, drop_cnt, crc_cnt, cap.size(), mis);
        end
        test_good_frame(add_fcs(rand_bytes(60)), "after_reset");
    endtask

`ifdef GMII_RX_MAC_FILTER_EN
    task automatic test_mac_filter();
        logic [47:0] das[3];
        bq_t p;
        das[0] = MAC;
        das[1] = 48'hFFFF_FFFF_FFFF;
        das[2] = 48'h0011_2233_4455;
        for (int j = 0; j < 3; j++) begin
            p = rand_bytes(60);
            for (int i = 0; i < 6; i++) p[i] = das[j][47-8*i -: 8];
            if (j < 2) begin
                test_good_frame(add_fcs(p), "mac_pass");
            end else begin
                clear_cap();
                send_frame(add_fcs(p), 7);
                idle(8);
                n_checks++;
                if (cap.size() != 0 || drop_cnt != 1) begin
                    n_fail++;
                    $display("FAIL mac_reject: got bytes=%0d drops=%0d, want 0 1", cap.size(), drop_cnt);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame(add_fcs(rand_bytes(60)), "good");
        test_bad_crc();
        test_drop_cases();
        test_back_to_back();
        test_lengths();
        test_reset_midframe();
`ifdef GMII_RX_MAC_FILTER_EN
        test_mac_filter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
